// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - receiver output handshake bundle (payload, flags, valid/ready)
interface uart_rx_param_if #(
  parameter int data_bits = 8
);

  logic [data_bits-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_error;
  logic                 parity_error;
  logic                 overrun;

  // receiver side: produces the frame register, consumes ready
  modport master (
    output data,
    output valid,
    output frame_error,
    output parity_error,
    output overrun,
    input  ready
  );

  // consumer side: reads the frame register, drives ready
  modport slave (
    input  data,
    input  valid,
    input  frame_error,
    input  parity_error,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with valid/ready output; optional macro UART_MAJORITY_EN
module uart_rx_param #(
  parameter int board_freq  = 50000000,
  parameter int baud_rate   = 9600,
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1,
  parameter int msb_first   = 1
) (
  input  logic             clk_board,
  input  logic             reset,
  input  logic             enable,
  input  logic             rx,
  output logic             busy,
  uart_rx_param_if.master  bus
);

  localparam int CPB = board_freq / baud_rate;
  localparam int CW  = $clog2(CPB);

  localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(data_bits - 1);
  localparam logic          LAST_STOP = 1'(stop_bits - 1);
  localparam logic          ODD_PAR   = (parity_mode == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BRK    = 3'd5;

  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_s_d;
  logic                 rx_fall;

  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic                 stop_idx;
  logic [data_bits-1:0] shreg;
  logic [data_bits-1:0] shifted;
  logic                 par_err;
  logic                 fr_err;
  logic                 done;
  logic                 last_stop;

  logic                 counting;
  logic                 samp_ev;
  logic                 samp_bit;

  // two-flop synchroniser on the asynchronous line plus a delayed copy for edge detection
  always_ff @(posedge clk_board) begin
    if (reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign rx_fall  = rx_s_d & ~rx_s;
  assign counting = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);
  assign busy     = (state != S_IDLE);

`ifdef UART_MAJORITY_EN
  logic maj_a;
  logic maj_b;
  logic maj_pend;

  // collect the votes at counter 1 and 0; the third vote is the live rx_s one cycle after expiry
  always_ff @(posedge clk_board) begin
    if (reset || !enable || !counting || done) begin
      maj_a    <= 1'b1;
      maj_b    <= 1'b1;
      maj_pend <= 1'b0;
    end else begin
      maj_pend <= (cnt == '0);
      if (cnt == CW'(1)) maj_a <= rx_s;
      if (cnt == '0)     maj_b <= rx_s;
    end
  end

  assign samp_ev  = maj_pend;
  assign samp_bit = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
  assign samp_ev  = counting && !done && (cnt == '0);
  assign samp_bit = rx_s;
`endif

  // place the newly sampled bit according to line bit order
  always_comb begin
    shifted = shreg;
    if (msb_first != 0) begin
      shifted = {shreg[data_bits-2:0], samp_bit};
    end else begin
      shifted = {samp_bit, shreg[data_bits-1:1]};
    end
  end

  // frame FSM: baud counting, bit assembly, parity/stop evaluation and completion
  always_ff @(posedge clk_board) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_err   <= 1'b0;
      fr_err    <= 1'b0;
      done      <= 1'b0;
      last_stop <= 1'b1;
    end else if (!enable) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      stop_idx <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (counting) begin
        cnt <= (cnt == '0) ? FULL_LOAD : cnt - CW'(1);
      end
      case (state)
        S_IDLE: begin
          if (rx_fall) begin
            state    <= S_START;
            cnt      <= HALF_LOAD;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            par_err  <= 1'b0;
            fr_err   <= 1'b0;
          end
        end
        S_START: begin
          if (samp_ev) begin
            state <= samp_bit ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (samp_ev) begin
            shreg <= shifted;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (parity_mode != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (samp_ev) begin
            par_err <= ((^shreg) ^ samp_bit) != ODD_PAR;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (done) begin
            state <= last_stop ? S_IDLE : S_BRK;
          end else if (samp_ev) begin
            if (!samp_bit) fr_err <= 1'b1;
            if (stop_idx == LAST_STOP) begin
              done      <= 1'b1;
              last_stop <= samp_bit;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        S_BRK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // output register and handshake: load on completion if free or being drained, else flag overrun
  always_ff @(posedge clk_board) begin
    if (reset) begin
      bus.data         <= '0;
      bus.valid        <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.parity_error <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      if (done && (!bus.valid || bus.ready)) begin
        bus.data         <= shreg;
        bus.frame_error  <= fr_err;
        bus.parity_error <= par_err;
        bus.valid        <= 1'b1;
      end else begin
        if (bus.valid && bus.ready) bus.valid <= 1'b0;
        if (done) bus.overrun <= 1'b1;
      end
      if (bus.valid && bus.ready) bus.overrun <= 1'b0;
    end
  end

endmodule
